// File: rtl/modcore_axi_burst_mem_if.sv
// AXI4 burst channel bundle between the modcore burst master and the on-chip burst memory.
// The slave modport is used by the memory; the master modport by whatever drives it.
interface modcore_axi_burst_mem_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [7:0]                      S_AXI_AWLEN;
    logic [1:0]                      S_AXI_AWBURST;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WLAST;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [7:0]                      S_AXI_ARLEN;
    logic [1:0]                      S_AXI_ARBURST;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RLAST;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/modcore_axi_burst_mem.sv
// AXI4 INCR/FIXED burst slave memory closing the modcore master's write-then-readback loop.
// One transaction in flight; every transaction returns through IDLE.
//
// state   | meaning
// IDLE    | waiting for AW or AR; round-robin when both are valid
// WDATA   | accepting write beats (WREADY=1)
// WRESP   | holding BVALID/BRESP until BREADY
// RDATA   | streaming read beats, next word prefetched
module modcore_axi_burst_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int C_MEM_WORDS        = 2**(C_S_AXI_ADDR_WIDTH-2)
) (
    input logic                    ACLK,
    input logic                    ARESET,
    modcore_axi_burst_mem_if.slave s_axi
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW/8;
    localparam int IW = C_S_AXI_ADDR_WIDTH-2;

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      len_q;
    logic [7:0]      beat_q;
    logic [1:0]      burst_q;
    logic            err_q;
    logic            last_was_wr_q;
    logic            awready_q, arready_q, wready_q, bvalid_q;
    logic [1:0]      bresp_q, rresp_q;
    logic            rvalid_q, rlast_q;
    logic [DW-1:0]   rdata_q;

    logic [DW-1:0]   mem [C_MEM_WORDS];

    logic            burst_ok;
    logic [IW-1:0]   idx_nxt;
    logic [IW-1:0]   rd_idx;
    logic [DW-1:0]   rd_word;
    logic            w_hs, r_hs, wlast_bad, pick_w, pick_r;
    logic [7:0]      r_nbeat;
    logic            unused_addr;

    assign burst_ok  = ~burst_q[1];
    assign idx_nxt   = (burst_q == 2'b01) ? idx_q + 1'b1 : idx_q;
    assign w_hs      = (state_q == S_WDATA) && wready_q && s_axi.S_AXI_WVALID;
    assign r_hs      = rvalid_q && s_axi.S_AXI_RREADY;
    assign wlast_bad = s_axi.S_AXI_WLAST != (beat_q == len_q);
    assign pick_w    = s_axi.S_AXI_AWVALID && (!s_axi.S_AXI_ARVALID || !last_was_wr_q);
    assign pick_r    = s_axi.S_AXI_ARVALID && !pick_w;
    // First beat reads the captured index; later beats prefetch the index after the handshake.
    assign rd_idx    = arready_q ? idx_q : idx_nxt;
    assign rd_word   = burst_ok ? mem[rd_idx] : '0;
    assign r_nbeat   = arready_q ? 8'd0 : beat_q + 8'd1;
    assign unused_addr = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK) begin
        if (w_hs && burst_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) mem[idx_q][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
            last_was_wr_q <= 1'b0;
            awready_q     <= 1'b0;
            arready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= '0;
            rlast_q       <= 1'b0;
        end else begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    beat_q <= '0;
                    if (pick_w) begin
                        awready_q     <= 1'b1;
                        wready_q      <= 1'b1;
                        idx_q         <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        len_q         <= s_axi.S_AXI_AWLEN;
                        burst_q       <= s_axi.S_AXI_AWBURST;
                        err_q         <= s_axi.S_AXI_AWBURST[1];
                        last_was_wr_q <= 1'b1;
                        state_q       <= S_WDATA;
                    end else if (pick_r) begin
                        arready_q     <= 1'b1;
                        idx_q         <= s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        len_q         <= s_axi.S_AXI_ARLEN;
                        burst_q       <= s_axi.S_AXI_ARBURST;
                        err_q         <= 1'b0;
                        last_was_wr_q <= 1'b0;
                        state_q       <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (w_hs) begin
                        idx_q  <= idx_nxt;
                        beat_q <= beat_q + 8'd1;
                        err_q  <= err_q | wlast_bad;
                        if (beat_q == len_q) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q || wlast_bad) ? 2'b10 : 2'b00;
                            state_q  <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= 2'b00;
                        state_q  <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (r_hs && rlast_q) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        rdata_q  <= '0;
                        rresp_q  <= 2'b00;
                        state_q  <= S_IDLE;
                    end else if (arready_q || r_hs) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_word;
                        rresp_q  <= burst_ok ? 2'b00 : 2'b10;
                        rlast_q  <= (r_nbeat == len_q);
                        beat_q   <= r_nbeat;
                        if (r_hs) idx_q <= idx_nxt;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
endmodule

// File: tb/tb_modcore_axi_burst_mem.sv
// Directed bench for modcore_axi_burst_mem: a word-array model feeds a queue of expected
// read beats that is popped as R handshakes occur.
module tb_modcore_axi_burst_mem;
    localparam int DW = 32;
    localparam int AW = 10;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;

    modcore_axi_burst_mem_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) bus ();

    modcore_axi_burst_mem #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (bus)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [256];
    rexp_t       sbq [$];
    logic [31:0] wq [$];
    logic [7:0]  cur_idx;
    logic [7:0]  cur_len;
    logic [1:0]  cur_burst;
    logic [1:0]  exp_bresp;
    logic        watch_ar = 1'b0;
    int          ar_early = 0;
    int          bv_seen = 0;
    logic        watch_bv = 1'b0;

    always @(negedge ACLK) begin
        if (watch_ar && bus.S_AXI_ARREADY) ar_early++;
        if (watch_bv && bus.S_AXI_BVALID) bv_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {22'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BRESP, bus.S_AXI_BVALID,
                bus.S_AXI_ARREADY, bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_RLAST, bus.S_AXI_RVALID};
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic aw_phase(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWLEN   = len;
        bus.S_AXI_AWBURST = burst;
        bus.S_AXI_AWVALID = 1'b1;
        cur_idx   = addr[9:2];
        cur_len   = len;
        cur_burst = burst;
        while (!bus.S_AXI_AWREADY && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        chk("awready", bus.S_AXI_AWREADY, 1);
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic drive_w(input int b, input logic [3:0] strb, input int last_beat);
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_WDATA  = wq[b];
        bus.S_AXI_WSTRB  = strb;
        bus.S_AXI_WLAST  = (b == last_beat);
    endtask

    task automatic w_phase(input int nsend, input logic [3:0] strb, input int last_beat);
        int   b = 0;
        int   t = 0;
        logic hs;
        drive_w(0, strb, last_beat);
        while (b < nsend && t < 200) begin
            hs = bus.S_AXI_WREADY;
            @(negedge ACLK);
            t++;
            if (hs) begin
                if (!cur_burst[1]) begin
                    for (int k = 0; k < 4; k++)
                        if (strb[k]) model[cur_idx][8*k +: 8] = wq[b][8*k +: 8];
                end
                if (cur_burst == 2'b01) cur_idx++;
                b++;
                if (b < nsend) drive_w(b, strb, last_beat);
                else begin
                    bus.S_AXI_WVALID = 1'b0;
                    bus.S_AXI_WLAST  = 1'b0;
                end
            end
        end
        bus.S_AXI_WVALID = 1'b0;
        chk("w_beats", b, nsend);
        exp_bresp = (cur_burst[1] || last_beat != int'(cur_len)) ? 2'b10 : 2'b00;
    endtask

    task automatic b_phase();
        int t = 0;
        bus.S_AXI_BREADY = 1'b1;
        while (!bus.S_AXI_BVALID && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        chk("bvalid", bus.S_AXI_BVALID, 1);
        chk("bresp", bus.S_AXI_BRESP, exp_bresp);
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b0;
        chk("bvalid_drop", bus.S_AXI_BVALID, 0);
    endtask

    task automatic ar_phase(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int         t = 0;
        logic [7:0] idx = addr[9:2];
        rexp_t      e;
        for (int i = 0; i <= int'(len); i++) begin
            e.d    = burst[1] ? 32'd0 : model[idx];
            e.resp = burst[1] ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            sbq.push_back(e);
            if (burst == 2'b01) idx++;
        end
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARLEN   = len;
        bus.S_AXI_ARBURST = burst;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        chk("arready", bus.S_AXI_ARREADY, 1);
        chk("rvalid_early", bus.S_AXI_RVALID, 0);
        @(negedge ACLK);
        bus.S_AXI_ARVALID = 1'b0;
        chk("r_latency", bus.S_AXI_RVALID, 1);
    endtask

    task automatic r_phase(input logic [3:0] pat);
        int          c = 0;
        int          t = 0;
        logic [31:0] held = '0;
        logic        stalled = 1'b0;
        rexp_t       e;
        while (sbq.size() > 0 && t < 200) begin
            bus.S_AXI_RREADY = pat[c % 4];
            c++;
            if (stalled) chk("r_hold", bus.S_AXI_RDATA, held);
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                e = sbq.pop_front();
                chk("rdata", bus.S_AXI_RDATA, e.d);
                chk("rresp", bus.S_AXI_RRESP, e.resp);
                chk("rlast", bus.S_AXI_RLAST, e.last);
                stalled = 1'b0;
            end else if (bus.S_AXI_RVALID) begin
                held    = bus.S_AXI_RDATA;
                stalled = 1'b1;
            end
            @(negedge ACLK);
            t++;
        end
        bus.S_AXI_RREADY = 1'b0;
        chk("r_remaining", sbq.size(), 0);
        chk("rvalid_end", bus.S_AXI_RVALID, 0);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        repeat (3) @(negedge ACLK);
        chk("reset_outs", all_outs(), 0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Simultaneous AW/AR after reset: write first, read only after the B handshake.
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_ARADDR  = 10'h080;
        bus.S_AXI_ARLEN   = 8'd3;
        bus.S_AXI_ARBURST = 2'b01;
        watch_ar = 1'b1;
        wq = '{32'h0404_0001, 32'h0404_0002, 32'h0404_0003, 32'h0404_0004};
        aw_phase(10'h080, 8'd3, 2'b01);
        w_phase(4, 4'hF, 3);
        b_phase();
        watch_ar = 1'b0;
        chk("ar_after_b", ar_early, 0);
        ar_phase(10'h080, 8'd3, 2'b01);
        r_phase(4'b1001);

        wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        aw_phase(10'h000, 8'd7, 2'b01);
        w_phase(8, 4'hF, 7);
        b_phase();
        ar_phase(10'h000, 8'd7, 2'b01);
        r_phase(4'b1111);

        wq = '{32'h1122_3344};
        aw_phase(10'h010, 8'd0, 2'b01);
        w_phase(1, 4'hF, 0);
        b_phase();
        wq = '{32'hAAAA_BBBB};
        aw_phase(10'h010, 8'd0, 2'b01);
        w_phase(1, 4'h3, 0);
        b_phase();
        ar_phase(10'h010, 8'd0, 2'b01);
        r_phase(4'b1111);

        wq = '{32'hA, 32'hB, 32'hC, 32'hD};
        aw_phase(10'h3FC, 8'd3, 2'b01);
        w_phase(4, 4'hF, 3);
        b_phase();
        ar_phase(10'h3FC, 8'd3, 2'b01);
        r_phase(4'b1111);

        wq = '{32'd5, 32'd6, 32'd7, 32'd8};
        aw_phase(10'h020, 8'd3, 2'b00);
        w_phase(4, 4'hF, 3);
        b_phase();
        ar_phase(10'h020, 8'd0, 2'b01);
        r_phase(4'b1111);

        wq = '{32'h3030_0000, 32'h3030_0001, 32'h3030_0002, 32'h3030_0003};
        aw_phase(10'h030, 8'd3, 2'b01);
        w_phase(4, 4'hF, 2);
        b_phase();

        wq = '{32'hDEAD_0000, 32'hBEEF_0000};
        aw_phase(10'h000, 8'd1, 2'b10);
        w_phase(2, 4'hF, 1);
        b_phase();
        ar_phase(10'h000, 8'd1, 2'b01);
        r_phase(4'b1111);
        ar_phase(10'h000, 8'd1, 2'b10);
        r_phase(4'b1111);

        // Reset in the middle of a write burst.
        wq = '{32'h4040_0000, 32'h4040_0001, 32'h4040_0002, 32'h4040_0003};
        aw_phase(10'h040, 8'd3, 2'b01);
        w_phase(2, 4'hF, 3);
        ARESET = 1'b1;
        #1;
        chk("midburst_reset_outs", all_outs(), 0);
        @(negedge ACLK);
        ARESET   = 1'b0;
        watch_bv = 1'b1;
        repeat (4) @(negedge ACLK);
        watch_bv = 1'b0;
        chk("no_b_after_reset", bv_seen, 0);
        wq = '{32'h5050_0000, 32'h5050_0001};
        aw_phase(10'h050, 8'd1, 2'b01);
        w_phase(2, 4'hF, 1);
        b_phase();
        ar_phase(10'h040, 8'd1, 2'b01);
        r_phase(4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
